// File: rtl/key_debounce_pkg.sv
// Shared FSM state encodings for the push-button debouncer.
// Imported by key_debounce and by any block that decodes its state.
package key_debounce_pkg;

  localparam logic [1:0] ST_RELEASED     = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  typedef enum logic [1:0] {
    RELEASED     = ST_RELEASED,
    PRESS_WAIT   = ST_PRESS_WAIT,
    PRESSED      = ST_PRESSED,
    RELEASE_WAIT = ST_RELEASE_WAIT
  } db_state_t;

endpackage

// File: rtl/key_debounce_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
// Ports: clk, clr (async active-low), d (async in), q (synchronised out).
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Push-button debouncer: sync, stability FSM, registered level and edge pulses.
// Ports: CLK, CLR (async active-low), KEY_N (raw, 0=pressed),
//   D (debounced level, 1=pressed), RISE/FALL (one-cycle edge pulses),
//   LONG (one-cycle long-press pulse, only with KEY_DEBOUNCE_LONG_EN defined).
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int DB_CYCLES   = 20000,
  parameter int HOLD_CYCLES = 1000000
) (
  input  logic CLK,
  input  logic CLR,
  input  logic KEY_N,
  output logic D,
  output logic RISE,
  output logic FALL
`ifdef KEY_DEBOUNCE_LONG_EN
  ,
  output logic LONG
`endif
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  if (DB_CYCLES < 2 || HOLD_CYCLES < 2) begin : g_bad_param
    $error("key_debounce: DB_CYCLES and HOLD_CYCLES must be >= 2");
  end

  logic      key_sync;
  logic      key_s;
  db_state_t state;
  logic [CW-1:0] cnt;

  // Synchroniser resets to 1 so a held key is not seen until after reset.
  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk(CLK),
    .clr(CLR),
    .d  (KEY_N),
    .q  (key_sync)
  );

  assign key_s = ~key_sync;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state <= RELEASED;
      cnt   <= '0;
      D     <= 1'b0;
      RISE  <= 1'b0;
      FALL  <= 1'b0;
    end else begin
      RISE <= 1'b0;
      FALL <= 1'b0;
      unique case (state)
        RELEASED: begin
          if (key_s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!key_s) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state <= PRESSED;
            cnt   <= '0;
            D     <= 1'b1;
            RISE  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!key_s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (key_s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state <= RELEASED;
            cnt   <= '0;
            D     <= 1'b0;
            FALL  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef KEY_DEBOUNCE_LONG_EN
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

  logic [HW-1:0] hold;
  logic          long_done;

  // hold is only ever non-zero in PRESSED and is cleared on the way
  // to RELEASE_WAIT, so each accepted press or bounce-back restarts it.
  // LONG fires after HOLD_CYCLES full cycles in PRESSED; long_done
  // keeps the saturated counter from re-firing.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      hold      <= '0;
      long_done <= 1'b0;
      LONG      <= 1'b0;
    end else begin
      LONG <= 1'b0;
      if (state == PRESSED) begin
        if (!key_s) begin
          hold      <= '0;
          long_done <= 1'b0;
        end else if (hold != HOLD_MAX) begin
          hold <= hold + 1'b1;
        end else if (!long_done) begin
          LONG      <= 1'b1;
          long_done <= 1'b1;
        end
      end
    end
  end
`endif

endmodule
